// File: rtl/uart_pkg.sv
// Shared definitions for the serial word receiver:
// FSM encoding, frame geometry and baud-tick derivation.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

    // Clocks per serial bit.
    function automatic int bit_ticks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Clocks from the start edge to the middle of the start bit.
    function automatic int half_ticks(input int clk_hz, input int baud);
        return bit_ticks(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, start detection and
// mid-bit sampling; emits one-cycle strobes on the stop sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_byte_data,
    output logic                 o_byte_valid,
    output logic                 o_frame_err,
    output logic                 o_idle,
    output logic                 o_start
);

    localparam int BIT_TICKS = bit_ticks(CLK_HZ, BAUD);
    localparam int HALF      = half_ticks(CLK_HZ, BAUD);
    localparam int CNT_W     = $clog2(BIT_TICKS + 1);

    localparam logic [CNT_W-1:0] C_BIT  = CNT_W'(BIT_TICKS);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    rx_state_t              r_state;
    rx_state_t              w_state_n;
    logic [1:0]             r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_n;
    logic [2:0]             r_bits;
    logic [2:0]             w_bits_n;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_n;
    logic                   w_rxs;
    logic                   w_byte_valid;
    logic                   w_frame_err;
    logic                   w_start;

    assign w_rxs = r_sync[1];

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_prev <= r_sync[1];
        end
    end

    // FSM state, tick counter, bit index and data shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bits  <= w_bits_n;
            r_shift <= w_shift_n;
        end
    end

    // Next state: sample when the tick counter reaches the bit point.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt + C_ONE;
        w_bits_n     = r_bits;
        w_shift_n    = r_shift;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        w_start      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (r_prev && !w_rxs) begin
                    w_start   = 1'b1;
                    w_state_n = S_START;
                    w_cnt_n   = C_ONE;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_n  = C_ONE;
                    w_bits_n = '0;
                    if (w_rxs) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == C_BIT) begin
                    w_cnt_n   = C_ONE;
                    w_shift_n = {w_rxs, r_shift[DATA_BITS-1:1]};
                    w_bits_n  = r_bits + 3'd1;
                    if (r_bits == 3'd7) begin
                        w_state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == C_BIT) begin
                    w_cnt_n   = '0;
                    w_state_n = S_IDLE;
                    if (w_rxs) begin
                        w_byte_valid = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign o_byte_data  = r_shift;
    assign o_byte_valid = w_byte_valid;
    assign o_frame_err  = w_frame_err;
    assign o_idle       = (r_state == S_IDLE);
    assign o_start      = w_start;

endmodule

// File: rtl/uart_word_rx.sv
// Serial word receiver: packs four UART bytes little-endian into a
// 32-bit word with idle timeout and a valid/ready output stage.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [1:0]  byte_cnt,
    output logic        frame_err,
    output logic        overrun,
    output logic        timeout
);

    localparam int WORD_W    = DATA_BITS * BYTES_PER_WORD;
    localparam int BIT_TICKS = bit_ticks(CLK_HZ, BAUD);
    localparam int LIMIT     = TIMEOUT_BITS * BIT_TICKS;
    localparam int TO_W      = $clog2(LIMIT + 1);

    localparam logic [TO_W-1:0] C_LAST = TO_W'(LIMIT - 1);
    localparam logic [1:0]      C_TOP  = 2'(BYTES_PER_WORD - 1);

    logic [DATA_BITS-1:0] w_byte;
    logic                 w_byte_valid;
    logic                 w_frame_err;
    logic                 w_idle;
    logic                 w_start;
    logic [WORD_W-1:0]    r_shadow;
    logic [WORD_W-1:0]    w_merged;
    logic [1:0]           r_byte_cnt;
    logic [WORD_W-1:0]    r_word;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_timeout;
    logic [TO_W-1:0]      r_idle_cnt;
    logic                 w_count_en;
    logic                 w_timeout_hit;
    logic                 w_done;
    logic                 w_hs;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (rx),
        .o_byte_data  (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_idle       (w_idle),
        .o_start      (w_start)
    );

    // Shadow word with the incoming byte dropped into its lane.
    always_comb begin
        w_merged = r_shadow;
        w_merged[r_byte_cnt*DATA_BITS +: DATA_BITS] = w_byte;
    end

    assign w_hs          = r_valid && word_ready;
    assign w_done        = w_byte_valid && (r_byte_cnt == C_TOP);
    assign w_count_en    = w_idle && (r_byte_cnt != 2'd0) && !w_start;
    assign w_timeout_hit = w_count_en && (r_idle_cnt == C_LAST);

    // Lane assembly; errors and idleness discard the partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow   <= '0;
            r_byte_cnt <= '0;
        end else if (w_byte_valid) begin
            r_shadow   <= w_merged;
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end else if (w_frame_err || w_timeout_hit) begin
            r_byte_cnt <= '0;
        end
    end

    // Idle clock counter, armed only while a word is partially built.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
        end else if (!w_count_en || w_timeout_hit) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Output word register; a full slot without handshake drops the new word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_done && (!r_valid || w_hs)) begin
            r_word  <= w_merged;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_done && r_valid && !w_hs;
            r_timeout   <= w_timeout_hit;
        end
    end

    assign word       = r_word;
    assign word_valid = r_valid;
    assign byte_cnt   = r_byte_cnt;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx with a scoreboard of expected
// words checked whenever the output register loads.
module tb_uart_word_rx;

    localparam int BT   = 16;
    localparam int HALF = BT / 2;
    localparam int LAT  = 2 + HALF + 9 * BT + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [1:0]  byte_cnt;
    logic        frame_err;
    logic        overrun;
    logic        timeout;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          load_cyc = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          to_cnt = 0;
    logic [31:0] exp_q[$];

    uart_word_rx #(
        .CLK_HZ       (16),
        .BAUD         (1),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_cnt   (byte_cnt),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every word load against the scoreboard.
    always @(posedge clk) begin
        logic        was_v;
        logic        was_r;
        logic [31:0] exp;
        was_v = word_valid;
        was_r = word_ready;
        cyc++;
        #1;
        if (reset) begin
            fe_cnt += int'(frame_err);
            ov_cnt += int'(overrun);
            to_cnt += int'(timeout);
            if (word_valid && (!was_v || was_r)) begin
                load_cyc = cyc;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word: got %h want none", word);
                end
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    checks++;
                    assert (word === exp) else begin
                        errors++;
                        $error("FAIL word: got %h want %h", word, exp);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop,
                             input int hs);
        for (int t = 0; t < 10 * BT; t++) begin
            int k;
            k = t / BT;
            if (k == 0) rx = 1'b0;
            else if (k <= 8) rx = b[k-1];
            else rx = stop;
            word_ready = (t == hs);
            @(negedge clk);
        end
        rx = 1'b1;
        word_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[i*8 +: 8];
            send_byte(b, 1'b1, -1);
        end
    endtask

    task automatic consume();
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        chk("consume_clears", {31'd0, word_valid}, 32'd0);
    endtask

    initial begin
        int t0;
        reset = 1'b0;
        rx = 1'b1;
        word_ready = 1'b0;
        #1;
        chk("rst_word", word, 32'd0);
        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_cnt", {30'd0, byte_cnt}, 32'd0);
        chk("rst_flags", {29'd0, frame_err, overrun, timeout}, 32'd0);
        tick(3);
        reset = 1'b1;
        tick(5);

        // 1: basic word with latency and hold
        exp_q.push_back(32'h12345678);
        send_byte(8'h78, 1'b1, -1);
        send_byte(8'h56, 1'b1, -1);
        chk("t1_cnt2", {30'd0, byte_cnt}, 32'd2);
        send_byte(8'h34, 1'b1, -1);
        t0 = cyc;
        send_byte(8'h12, 1'b1, -1);
        chk("t1_latency", load_cyc - t0, LAT);
        tick(20);
        chk("t1_hold_valid", {31'd0, word_valid}, 32'd1);
        chk("t1_hold_word", word, 32'h12345678);
        chk("t1_cnt0", {30'd0, byte_cnt}, 32'd0);
        consume();

        // 2: framing error discards partial word
        send_byte(8'hAA, 1'b1, -1);
        send_byte(8'hBB, 1'b0, -1);
        tick(20);
        chk("t2_fe_pulses", fe_cnt, 1);
        chk("t2_cnt0", {30'd0, byte_cnt}, 32'd0);
        exp_q.push_back(32'hDDCCBBAA);
        send_word(32'hDDCCBBAA);
        chk("t2_valid", {31'd0, word_valid}, 32'd1);
        consume();

        // 3: short low glitch is ignored
        exp_q.push_back(32'h44332211);
        send_byte(8'h11, 1'b1, -1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        chk("t3_cnt", {30'd0, byte_cnt}, 32'd1);
        chk("t3_flags", fe_cnt + ov_cnt + to_cnt, 1);
        send_byte(8'h22, 1'b1, -1);
        send_byte(8'h33, 1'b1, -1);
        send_byte(8'h44, 1'b1, -1);
        consume();

        // 4: overrun, then same-cycle handshake and reload
        exp_q.push_back(32'hA1A2A3A4);
        send_word(32'hA1A2A3A4);
        send_word(32'hB1B2B3B4);
        chk("t4_overrun", ov_cnt, 1);
        chk("t4_word_kept", word, 32'hA1A2A3A4);
        chk("t4_valid", {31'd0, word_valid}, 32'd1);
        exp_q.push_back(32'hC1C2C3C4);
        send_byte(8'hC4, 1'b1, -1);
        send_byte(8'hC3, 1'b1, -1);
        send_byte(8'hC2, 1'b1, -1);
        send_byte(8'hC1, 1'b1, LAT - 1);
        chk("t4_reload_word", word, 32'hC1C2C3C4);
        chk("t4_reload_valid", {31'd0, word_valid}, 32'd1);
        chk("t4_no_overrun", ov_cnt, 1);
        consume();

        // 5: idle timeout
        send_byte(8'h01, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        chk("t5_cnt2", {30'd0, byte_cnt}, 32'd2);
        tick(300);
        chk("t5_not_yet", to_cnt, 0);
        tick(40);
        chk("t5_timeout", to_cnt, 1);
        chk("t5_cnt0", {30'd0, byte_cnt}, 32'd0);
        exp_q.push_back(32'h0D0C0B0A);
        send_word(32'h0D0C0B0A);
        consume();

        // 6: asynchronous reset during data bit 4
        exp_q.push_back(32'h55667788);
        send_word(32'h55667788);
        send_byte(8'h99, 1'b1, -1);
        rx = 1'b0;
        tick(BT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1 ^ i[0];
            tick(BT);
        end
        rx = 1'b0;
        tick(HALF);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_word", word, 32'd0);
        chk("t6_valid", {31'd0, word_valid}, 32'd0);
        chk("t6_cnt", {30'd0, byte_cnt}, 32'd0);
        chk("t6_flags", {29'd0, frame_err, overrun, timeout}, 32'd0);
        rx = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(20);
        exp_q.push_back(32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        chk("t6_valid_after", {31'd0, word_valid}, 32'd1);
        consume();

        tick(10);
        chk("sb_empty", exp_q.size(), 0);
        chk("fe_total", fe_cnt, 1);
        chk("ov_total", ov_cnt, 1);
        chk("to_total", to_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial receive front end that turns a raw 8N1 UART line into 32-bit words for the CPU instruction-load path and the memory-response path. It oversamples the line with a baud-tick counter and assembles four bytes little-endian into one word. It presents each completed word on a valid/ready handshake with error flags. One instance sits directly upstream of each serial consumer, on `instr_rx` and on `mem_rx`.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `BAUD`, default 115200: line rate.
- `TIMEOUT_BITS`, default 20: idle bit-times allowed between bytes of one word before the partial word is discarded.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: raw serial line, idle high, asynchronous to `clk`.
- `word`, out, 32: assembled word; byte 0 received is in [7:0].
- `word_valid`, out, 1: `word` holds an unconsumed word.
- `word_ready`, in, 1: consumer accepts `word` on a rising edge where `word_valid` and `word_ready` are both 1.
- `byte_cnt`, out, 2: bytes of the current word received so far.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun`, out, 1: one-cycle pulse when a completed word is dropped.
- `timeout`, out, 1: one-cycle pulse when a partial word is discarded for idleness.

## Operation
- Derived constants: BIT_TICKS = CLK_HZ/BAUD (integer division); HALF = BIT_TICKS/2.
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- The FSM has four states: IDLE, START, DATA, STOP.
- **IDLE:** start is detected only on a 1→0 transition of synced rx. A line held low, for example after a framing error, never retriggers.
- **START:** synced rx is sampled HALF cycles after the falling edge.
  - Sample 0 → go to DATA.
  - Sample 1 → glitch; return to IDLE with no flags.
- **DATA:** 8 samples spaced BIT_TICKS apart, shifted in LSB-first; go to STOP after the 8th sample.
- **STOP:** one sample BIT_TICKS after bit 7.
  - Sample 1 → the byte is written into lane `byte_cnt` of the word shadow register; `byte_cnt` increments, wrapping 3→0; return to IDLE.
  - Sample 0 → `frame_err` pulse; `byte_cnt` ← 0; partial word discarded; return to IDLE.
- **Word completion:** a valid stop bit with `byte_cnt`==3 completes a word.
  - `word_valid`==0 → load `word` and set `word_valid`.
  - `word_valid`==1 and handshake in the same cycle → load the new word; `word_valid` stays 1.
  - `word_valid`==1 and no handshake → `overrun` pulse; the new word is dropped; `word` is unchanged.
- **Handshake:** `word_valid` clears on a handshake unless a new word loads in that same cycle.
- **Timeout:** while in IDLE with `byte_cnt`≠0, an idle counter counts clocks.
  - It clears whenever a start is detected.
  - At TIMEOUT_BITS×BIT_TICKS clocks: `timeout` pulse, `byte_cnt` ← 0.
- **Reset:** asserting `reset` at any time, including mid-byte, immediately forces IDLE and clears all counters.

## Timing
- Reset values: `word`=0, `word_valid`=0, `byte_cnt`=0, `frame_err`=0, `overrun`=0, `timeout`=0; FSM in IDLE.
- Let T0 be the first cycle synced rx is 0; synced rx lags raw `rx` by 2 cycles. Sample instants are T0+HALF+k·BIT_TICKS, for k=0 (start), 1..8 (data), 9 (stop).
- Flags, `byte_cnt` update, and `word`/`word_valid` are registered: they change on the edge after the stop sample.
- Latency, raw start edge to `word_valid` for the 4th byte's frame: 2 + HALF + 9·BIT_TICKS + 1 cycles after that frame's start edge.
- `word` is stable while `word_valid`=1 and no handshake occurs.
- The earliest next start is detected on the cycle after the STOP sample, which permits back-to-back frames.

## Structure
- Shared package `uart_pkg` contains:
  - the FSM state encoding (IDLE/START/DATA/STOP);
  - DATA_BITS=8;
  - BYTES_PER_WORD=4;
  - the BIT_TICKS/HALF derivation function.
- Sub-module `uart_rx_byte` contains the synchronizer, FSM, and bit sampler. It outputs `byte_data`, `byte_valid` and `frame_err`.
- `uart_word_rx` contains the lane assembly, idle timeout, and output handshake.

## Test plan
All scenarios use CLK_HZ=16, BAUD=1 (BIT_TICKS=16), TIMEOUT_BITS=20.

1. **Basic word:** send 0x78, 0x56, 0x34, 0x12 with `word_ready`=0 → `word`=0x12345678 and `word_valid`=1 at the stated latency, held until `word_ready`=1, then clears on the next edge.
2. **Framing error:** send 0xAA, then 0xBB with stop=0 → `frame_err` 1-cycle pulse, `byte_cnt`=0. Then send 0xAA, 0xBB, 0xCC, 0xDD → `word`=0xDDCCBBAA.
3. **Glitch rejection:** drive `rx` low for 4 cycles mid-idle → no byte, `byte_cnt` unchanged, no flags.
4. **Overrun and same-cycle handshake:** two words back-to-back with `word_ready`=0 → `overrun` pulse, `word` keeps the first value. Repeat with `word_ready`=1 on the completion cycle → second word loads and `word_valid` stays 1.
5. **Timeout:** send 2 bytes, then idle 320 cycles → `timeout` pulse, `byte_cnt`=0. The next 4 bytes form a clean word.
6. **Reset mid-frame:** assert `reset` during data bit 4 → all outputs 0 asynchronously. After release, a full word receives correctly.
